// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: 6502 bus target with an 8-register I/O window, scanline IRQ timer,
// vblank NMI generator and frame watchdog driving the CPU reset.
module cpu_bus_responder #(
   parameter logic [15:0] BASE_ADDR   = 16'h1800,
   parameter logic [7:0]  WDOG_FRAMES = 8'd8,
   parameter logic [7:0]  NMI_WIDTH   = 8'd16,
   parameter logic [7:0]  WDRST_WIDTH = 8'd32
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        phi2,
   input  logic        rw_n,
   input  logic [15:0] a,
   input  logic [7:0]  cpu_dout,
   output logic [7:0]  cpu_din,
   output logic        sel,
   input  logic        line_tick,
   input  logic        vblank,
   output logic        irq_n,
   output logic        nmi_n,
   output logic        wd_reset_n
);
   logic       phi2_q, vblank_q, fall, vb_rise, we, ack, kick, period_wr, expire, fire;
   logic       irq_pend, wd_fired, nmi_en, irq_en;
   logic [2:0] idx;
   logic [7:0] period, scratch, line_cnt, wd_cnt, nmi_cnt, wdr_cnt, rd;

   assign sel        = a[15:3] == BASE_ADDR[15:3];
   assign idx        = a[2:0];
   assign fall       = phi2_q & ~phi2;
   assign vb_rise    = vblank & ~vblank_q;
   assign we         = fall & sel & ~rw_n;
   assign ack        = we && idx == 3'd1;
   assign period_wr  = we && idx == 3'd2;
   assign kick       = we && idx == 3'd3;
   assign expire     = line_tick && period != 8'd0 && line_cnt == period - 8'd1;
   // a kick landing on the same vblank edge prevents the watchdog from firing
   assign fire       = vb_rise && !kick && wd_cnt == WDOG_FRAMES - 8'd1;
   assign nmi_n      = nmi_cnt == 8'd0;
   assign wd_reset_n = wdr_cnt == 8'd0;

   always_comb begin
      rd = idx == 3'd0 ? {vblank, 5'b0, wd_fired, irq_pend} :
           idx == 3'd2 ? period :
           idx == 3'd4 ? scratch :
           idx == 3'd5 ? line_cnt :
           idx == 3'd6 ? {6'b0, nmi_en, irq_en} :
           idx == 3'd7 ? wd_cnt : 8'h00;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         phi2_q   <= 1'b0;
         vblank_q <= 1'b0;
         cpu_din  <= 8'h00;
         irq_n    <= 1'b1;
         irq_pend <= 1'b0;
         wd_fired <= 1'b0;
         nmi_en   <= 1'b0;
         irq_en   <= 1'b0;
         period   <= 8'h00;
         scratch  <= 8'h00;
         line_cnt <= 8'h00;
         wd_cnt   <= 8'h00;
         nmi_cnt  <= 8'h00;
         wdr_cnt  <= 8'h00;
      end else begin
         phi2_q   <= phi2;
         vblank_q <= vblank;
         cpu_din  <= sel ? rd : 8'h00;
         irq_n    <= ~(irq_pend & irq_en);
         if (period_wr) period <= cpu_dout;
         if (we && idx == 3'd4) scratch <= cpu_dout;
         if (we && idx == 3'd6) {nmi_en, irq_en} <= cpu_dout[1:0];
         line_cnt <= (period_wr || period == 8'd0 || expire) ? 8'h00 :
                     line_tick ? line_cnt + 8'd1 : line_cnt;
         irq_pend <= expire | (irq_pend & ~ack);
         nmi_cnt  <= (vb_rise && nmi_en && nmi_cnt == 8'd0) ? NMI_WIDTH :
                     nmi_cnt != 8'd0 ? nmi_cnt - 8'd1 : 8'h00;
         wdr_cnt  <= fire ? WDRST_WIDTH : wdr_cnt != 8'd0 ? wdr_cnt - 8'd1 : 8'h00;
         wd_fired <= wd_fired | fire;
         // the count is held at WDOG_FRAMES until the reset pulse finishes
         wd_cnt   <= (kick || wdr_cnt == 8'd1) ? 8'h00 :
                     (vb_rise && wd_cnt != WDOG_FRAMES) ? wd_cnt + 8'd1 : wd_cnt;
      end
   end
endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb_cpu_bus_responder: directed checks of bus decode, IRQ timer, NMI pulse and watchdog.
module tb_cpu_bus_responder;
   logic        clk = 1'b0, reset_n = 1'b0, phi2 = 1'b0, rw_n = 1'b1;
   logic [15:0] a = 16'h0000;
   logic [7:0]  cpu_dout = 8'h00, cpu_din;
   logic        sel, line_tick = 1'b0, vblank = 1'b0, irq_n, nmi_n, wd_reset_n;
   logic [7:0]  d;
   logic        s;
   int          checks = 0, errors = 0;

   cpu_bus_responder dut (
      .clk(clk), .reset_n(reset_n), .phi2(phi2), .rw_n(rw_n), .a(a),
      .cpu_dout(cpu_dout), .cpu_din(cpu_din), .sel(sel), .line_tick(line_tick),
      .vblank(vblank), .irq_n(irq_n), .nmi_n(nmi_n), .wd_reset_n(wd_reset_n)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // optional line_tick / vblank rise land on the same clk as the write commit
   task automatic bus_write(input logic [15:0] addr, input logic [7:0] data,
                            input bit tick = 1'b0, input bit vb = 1'b0);
      @(negedge clk);
      a = addr; rw_n = 1'b0; cpu_dout = data; phi2 = 1'b1;
      repeat (2) @(negedge clk);
      phi2 = 1'b0;
      line_tick = tick;
      if (vb) vblank = 1'b1;
      @(negedge clk);
      line_tick = 1'b0;
      if (vb) vblank = 1'b0;
      rw_n = 1'b1; a = 16'h0000;
   endtask

   task automatic bus_read(input logic [15:0] addr, output logic [7:0] data, output logic sl);
      @(negedge clk);
      a = addr; rw_n = 1'b1; phi2 = 1'b1;
      sl = sel;
      repeat (2) @(negedge clk);
      data = cpu_din;
      phi2 = 1'b0;
      @(negedge clk);
      a = 16'h0000;
   endtask

   task automatic tick();
      @(negedge clk);
      line_tick = 1'b1;
      @(negedge clk);
      line_tick = 1'b0;
   endtask

   task automatic vb_pulse();
      @(negedge clk);
      vblank = 1'b1;
      @(negedge clk);
      vblank = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      // reset
      repeat (4) @(negedge clk);
      chk("rst_cpu_din", cpu_din, 8'h00);
      chk("rst_irq_n", {7'b0, irq_n}, 8'h01);
      chk("rst_nmi_n", {7'b0, nmi_n}, 8'h01);
      chk("rst_wd_reset_n", {7'b0, wd_reset_n}, 8'h01);
      reset_n = 1'b1;
      bus_read(16'h1800, d, s);
      chk("rst_status", d, 8'h00);
      chk("rst_sel", {7'b0, s}, 8'h01);

      // IRQ timer period 3
      bus_write(16'h1802, 8'h03);
      bus_write(16'h1806, 8'h01);
      tick(); tick(); tick();
      chk("irq_n_same_clk", {7'b0, irq_n}, 8'h01);
      @(negedge clk);
      chk("irq_n_fall", {7'b0, irq_n}, 8'h00);
      bus_read(16'h1805, d, s);
      chk("line_cnt_wrap", d, 8'h00);
      bus_read(16'h1802, d, s);
      chk("period_rb", d, 8'h03);
      bus_write(16'h1801, 8'h00);
      chk("irq_n_ack_lat", {7'b0, irq_n}, 8'h00);
      @(negedge clk);
      chk("irq_n_acked", {7'b0, irq_n}, 8'h01);

      // ack on the same clk as expiry: set wins
      tick(); tick(); tick();
      repeat (2) @(negedge clk);
      chk("irq_n_again", {7'b0, irq_n}, 8'h00);
      tick(); tick();
      bus_read(16'h1805, d, s);
      chk("line_cnt_2", d, 8'h02);
      bus_write(16'h1801, 8'h00, 1'b1);
      chk("irq_n_sim0", {7'b0, irq_n}, 8'h00);
      @(negedge clk);
      chk("irq_n_sim1", {7'b0, irq_n}, 8'h00);
      bus_read(16'h1800, d, s);
      chk("status_pend", d, 8'h01);
      bus_write(16'h1801, 8'h00);
      @(negedge clk);
      chk("irq_n_cleared", {7'b0, irq_n}, 8'h01);

      // NMI: 16-clk pulse, retrigger ignored
      bus_write(16'h1806, 8'h02);
      bus_read(16'h1806, d, s);
      chk("ctrl_rb", d, 8'h02);
      vblank = 1'b1;
      for (int i = 1; i <= 18; i++) begin
         @(negedge clk);
         chk($sformatf("nmi_n_%0d", i), {7'b0, nmi_n}, (i <= 16) ? 8'h00 : 8'h01);
         if (i == 3) vblank = 1'b0;
         if (i == 4) vblank = 1'b1;
      end
      vblank = 1'b0;

      // watchdog fires after 8 unkicked vblank edges
      bus_write(16'h1803, 8'h00);
      bus_read(16'h1807, d, s);
      chk("wd_cnt_kicked", d, 8'h00);
      repeat (7) vb_pulse();
      bus_read(16'h1807, d, s);
      chk("wd_cnt_7", d, 8'h07);
      chk("wd_reset_n_7", {7'b0, wd_reset_n}, 8'h01);
      @(negedge clk);
      vblank = 1'b1;
      for (int i = 1; i <= 34; i++) begin
         @(negedge clk);
         chk($sformatf("wd_reset_n_%0d", i), {7'b0, wd_reset_n}, (i <= 32) ? 8'h00 : 8'h01);
         if (i == 1) vblank = 1'b0;
      end
      bus_read(16'h1800, d, s);
      chk("status_wd_fired", d, 8'h02);
      bus_read(16'h1807, d, s);
      chk("wd_cnt_cleared", d, 8'h00);

      // kick on the 8th vblank edge prevents firing
      repeat (7) vb_pulse();
      bus_write(16'h1803, 8'h00, 1'b0, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("wd_kick_nopulse_%0d", i), {7'b0, wd_reset_n}, 8'h01);
         @(negedge clk);
      end
      bus_read(16'h1807, d, s);
      chk("wd_cnt_kick_win", d, 8'h00);
      bus_read(16'h1800, d, s);
      chk("wd_fired_sticky", d, 8'h02);

      // scratch and out-of-window accesses
      bus_write(16'h1804, 8'hA5);
      bus_read(16'h1804, d, s);
      chk("scratch_rb", d, 8'hA5);
      bus_write(16'h1C04, 8'h11);
      bus_read(16'h1804, d, s);
      chk("scratch_kept", d, 8'hA5);
      bus_read(16'h1808, d, s);
      chk("oow_sel", {7'b0, s}, 8'h00);
      chk("oow_din", d, 8'h00);
      bus_read(16'h17FF, d, s);
      chk("below_sel", {7'b0, s}, 8'h00);

      // reset during an NMI pulse
      @(negedge clk);
      vblank = 1'b1;
      repeat (3) @(negedge clk);
      chk("nmi_n_mid", {7'b0, nmi_n}, 8'h00);
      reset_n = 1'b0;
      @(negedge clk);
      chk("nmi_n_reset", {7'b0, nmi_n}, 8'h01);
      vblank = 1'b0;
      reset_n = 1'b1;
      bus_read(16'h1800, d, s);
      chk("status_after_reset", d, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
